mc_mac_unit: RTL and testbench
==============================

Name: mc_mac_unit

Overview:
Iterative multi-cycle multiply-accumulate unit, next generation of the FBDSP multi-cycle multiplier wrapper. Splits operand bb into II chunks and retires one partial product per cycle. Supports signed or unsigned operands per operation, a sustained initiation interval of II cycles with a ready handshake, and an optional running accumulator. Sits behind the FBDSP top-level DSP wrapper as its arithmetic core.

Parameters:
N, 8, width of operand aa
M, 8, width of operand bb; M % II == 0 (elaboration assertion)
II, 4, initiation interval = cycles per operation; legal range 1..M
ACC_W, N+M+4, accumulator width; must be >= N+M

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
sign  in  1  1 = two's-complement aa/bb, 0 = unsigned; latched on accept
acc_en  in  1  add this product into acc_out on completion; latched on accept
acc_clr  in  1  synchronous clear of acc_out, acts on any edge
aa  in  N  multiplicand, latched on accept
bb  in  M  multiplier, latched on accept
ready  out  1  start will be accepted this cycle
out_valid  out  1  one-cycle pulse, new result on out
out  out  N+M  product modulo 2^(N+M), held until next completion
acc_out  out  ACC_W  accumulator, wraps modulo 2^ACC_W
drop  out  1  one-cycle pulse: start asserted while ready=0

Behaviour:
- Reset (async, rst_n=0): state IDLE, count=0, out=0, acc_out=0, out_valid=0, drop=0, operand regs=0; ready=1 once rst_n is released.
- K = M/II chunk width. Chunk i = bb[i*K +: K].
- States IDLE, RUN. count 0..II-1 valid in RUN.
- ready = (state==IDLE) || (state==RUN && count==II-1). Combinational.
- Accept at edge E0 (start && ready): latch aa, bb, sign, acc_en; clear partial sum; state RUN, count=0.
- RUN edge with count=c: partial sum += pp(c) << (c*K), truncated to N+M; count++.
- pp(c): aa sign-extended to N+M if sign, else zero-extended. Chunk c is unsigned, except chunk II-1, which is signed when sign=1. II=1 therefore gives a full signed multiply.
- Completion edge (count==II-1): out <= final sum; out_valid=1 in the following cycle.
  - If start is present on the completion edge, reload and stay RUN with count=0.
  - Otherwise go to IDLE.
- Latency: start accepted at E0 -> out_valid high in the cycle after edge E_II. Back-to-back throughput is one result per II cycles.
- Accumulate on completion edge, when latched acc_en=1: acc_out <= acc_out + sext/zext(product) to ACC_W, extension per latched sign.
- acc_clr on a non-completion edge: acc_out <= 0.
- acc_clr on a completion edge with acc_en: acc_out <= product (clear, then add).
- acc_clr on a completion edge without acc_en: acc_out <= 0.
- start while ready=0: ignored and drop pulses next cycle. The in-flight operation and its inputs are untouched.
- Input changes on aa/bb/sign after accept have no effect.
- Reset mid-operation aborts the operation. No out_valid is produced and all outputs return to their reset values.

Decomposition:
- Package mcmac_pkg: state enum {IDLE, RUN}; function chunk_w(M, II); localparam count width = $clog2(II) with a minimum of 1.
- Sub-module mcmac_pp: combinational K x N partial-product generator.
  - Inputs: aa, chunk, sign, is_top.
  - Output: N+M-bit shift-ready term.
- Top holds the FSM, counter, sum register and accumulator.

Test Plan:
1. N=M=8, II=4, sign=0, aa=0xFF, bb=0xFF -> out=0xFE01; out_valid exactly 4 cycles after the accept edge; ready low for the 3 intermediate cycles.
2. sign=1, pairs 0xFF x 0x80, then 0xFD x 0x05, then 0x80 x 0x80 -> results 0x0080, 0xFFF1, 0x4000 respectively.
3. 50 random operands, start every 4 cycles, random sign -> 50 out_valid pulses spaced 4 cycles apart; every out matches the behavioural model; drop never pulses.
4. start 2 cycles after an accept, with aa=0x01 and bb=0x01 -> drop pulse; first result is unaffected; no extra out_valid.
5. acc_clr, then unsigned 3x4 and 5x6 with acc_en=1 -> acc_out=12, then 42. Next op 2x2 with acc_clr on its completion edge -> acc_out=4. Signed 0xFF x 0x01 with acc_en -> acc_out=3.
6. rst_n low while count==2 -> out=0, acc_out=0, no out_valid; after release, start 7x9 -> out=0x003F with normal latency.
7. Repeat scenarios 1-3 with II=1 and II=8 -> the same results, with latencies of 1 and 8 cycles respectively.

Source files
------------

// File: rtl/mcmac_pkg.sv
// Shared types and sizing helpers for the iterative multiply-accumulate unit.
package mcmac_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CNT_W_MIN = 1;

   function automatic int chunk_w(input int m, input int ii);
      return m / ii;
   endfunction

   function automatic int cnt_w(input int ii);
      return (ii > 1) ? $clog2(ii) : CNT_W_MIN;
   endfunction

endpackage

// File: rtl/mcmac_pp.sv
// Partial-product generator: one K-bit chunk of bb times aa, N+M bits wide.
module mcmac_pp #(
   parameter int N = 8,
   parameter int M = 8,
   parameter int K = 2
) (
   input  logic [N-1:0]   aa,
   input  logic [K-1:0]   chunk,
   input  logic           sign,
   input  logic           is_top,
   output logic [N+M-1:0] term
);

   localparam int W = N + M;

   logic [W-1:0] a_ext;
   logic [W-1:0] c_ext;

   // only the top chunk carries the sign of bb
   always_comb begin
      a_ext = {{M{sign & aa[N-1]}}, aa};
      c_ext = {{(W-K){sign & is_top & chunk[K-1]}}, chunk};
      term  = a_ext * c_ext;
   end

endmodule

// File: rtl/mc_mac_unit.sv
// Iterative multi-cycle MAC: retires one K-bit chunk of bb per cycle,
// II cycles per product, with an optional running accumulator.
module mc_mac_unit
   import mcmac_pkg::*;
#(
   parameter int N     = 8,
   parameter int M     = 8,
   parameter int II    = 4,
   parameter int ACC_W = N + M + 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign,
   input  logic             acc_en,
   input  logic             acc_clr,
   input  logic [N-1:0]     aa,
   input  logic [M-1:0]     bb,
   output logic             ready,
   output logic             out_valid,
   output logic [N+M-1:0]   out,
   output logic [ACC_W-1:0] acc_out,
   output logic             drop
);

   localparam int W  = N + M;
   localparam int K  = chunk_w(M, II);
   localparam int CW = cnt_w(II);
   localparam logic [CW-1:0] LAST = CW'(II - 1);

   if (II < 1 || II > M || (M % II) != 0) begin : g_bad_ii
      $error("mc_mac_unit: II must divide M and lie in 1..M");
   end
   if (ACC_W < W) begin : g_bad_acc
      $error("mc_mac_unit: ACC_W must be >= N+M");
   end

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   count;
   logic [W-1:0]    sum;
   logic [N-1:0]    a_r;
   logic [M-1:0]    b_r;
   logic            sign_r;
   logic            acc_en_r;

   logic            last;
   logic            accept;
   logic [31:0]     sh;
   logic [K-1:0]    chunk;
   logic [W-1:0]    term;
   logic [W-1:0]    sum_nx;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_base;

   assign last   = (state == RUN) && (count == LAST);
   assign ready  = (state == IDLE) || last;
   assign accept = start && ready;

   always_comb begin
      sh       = 32'(count) * 32'(K);
      chunk    = K'(b_r >> sh);
      sum_nx   = sum + (term << sh);
      prod_ext = sign_r ? ACC_W'($signed(sum_nx)) : ACC_W'(sum_nx);
      acc_base = acc_clr ? '0 : acc_out;
   end

   mcmac_pp #(
      .N(N),
      .M(M),
      .K(K)
   ) u_pp (
      .aa    (a_r),
      .chunk (chunk),
      .sign  (sign_r),
      .is_top(last),
      .term  (term)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last && !start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         sum       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         sign_r    <= 1'b0;
         acc_en_r  <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         acc_out   <= '0;
         drop      <= 1'b0;
      end else begin
         out_valid <= last;
         drop      <= start && !ready;
         if (accept) begin
            a_r      <= aa;
            b_r      <= bb;
            sign_r   <= sign;
            acc_en_r <= acc_en;
            sum      <= '0;
            count    <= '0;
         end else if (state == RUN && !last) begin
            sum   <= sum_nx;
            count <= count + 1'b1;
         end
         if (last) out <= sum_nx;
         // clear-then-add when both land on the completion edge
         if (last && acc_en_r) acc_out <= acc_base + prod_ext;
         else if (acc_clr)     acc_out <= '0;
      end
   end

endmodule

// File: tb/tb_mc_mac_unit.sv
// Self-checking bench for mc_mac_unit at II = 4, 1 and 8.
module tb_mc_mac_unit;

   localparam int IIS [3] = '{4, 1, 8};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start [3];
   logic       sign = 1'b0;
   logic       acc_en = 1'b0;
   logic       acc_clr = 1'b0;
   logic [7:0] aa = '0;
   logic [7:0] bb = '0;

   logic        ready [3];
   logic        out_valid [3];
   logic        drop [3];
   logic [15:0] out_v [3];
   logic [19:0] acc_v [3];

   int          n_pass = 0;
   int          n_total = 0;
   logic [19:0] acc_model = '0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mc_mac_unit #(
         .N(8), .M(8), .II(IIS[g]), .ACC_W(20)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .start    (start[g]),
         .sign     (sign),
         .acc_en   (acc_en),
         .acc_clr  (acc_clr),
         .aa       (aa),
         .bb       (bb),
         .ready    (ready[g]),
         .out_valid(out_valid[g]),
         .out      (out_v[g]),
         .acc_out  (acc_v[g]),
         .drop     (drop[g])
      );
   end

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int ref_mul(input logic [7:0] a, input logic [7:0] b,
                                  input logic s);
      int x;
      int y;
      x = s ? int'($signed(a)) : int'(a);
      y = s ? int'($signed(b)) : int'(b);
      return x * y;
   endfunction

   // Starts one op on DUT d from a negedge; lat counts cycles from accept edge.
   task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic en, input logic clr_done,
                         output logic [15:0] res, output int lat,
                         output int low_cnt);
      int ii;
      int p;
      ii = IIS[d];
      p = ref_mul(a, b, s);
      aa = a; bb = b; sign = s; acc_en = en; start[d] = 1'b1;
      if (en) acc_model = (clr_done ? 20'd0 : acc_model) + 20'(p);
      else if (clr_done) acc_model = '0;
      lat = -1; low_cnt = 0; res = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start[d] = 1'b0;
         acc_clr = 1'b0;
         if (out_valid[d]) begin
            lat = k - 1;
            res = out_v[d];
            break;
         end
         if (!ready[d]) low_cnt++;
         if (clr_done && k == ii) acc_clr = 1'b1;
      end
      acc_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      for (int d = 0; d < 3; d++) begin
         n_total++;
         if (out_v[d] !== 16'h0) $display("FAIL reset_out[%0d] got %h exp 0", d, out_v[d]);
         else n_pass++;
         n_total++;
         if (acc_v[d] !== 20'h0) $display("FAIL reset_acc[%0d] got %h exp 0", d, acc_v[d]);
         else n_pass++;
         n_total++;
         if (out_valid[d] !== 1'b0 || drop[d] !== 1'b0)
            $display("FAIL reset_pulse[%0d] got v=%b d=%b exp 0 0", d, out_valid[d], drop[d]);
         else n_pass++;
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_total++;
         if (ready[d] !== 1'b1) $display("FAIL reset_ready[%0d] got %b exp 1", d, ready[d]);
         else n_pass++;
      end
   endtask

   task automatic test_basic(input int d);
      logic [15:0] res;
      int lat, low;
      run_op(d, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, res, lat, low);
      n_total++;
      if (res !== 16'hFE01) $display("FAIL basic_out[ii=%0d] got %h exp fe01", IIS[d], res);
      else n_pass++;
      n_total++;
      if (lat != IIS[d]) $display("FAIL basic_lat[ii=%0d] got %0d exp %0d", IIS[d], lat, IIS[d]);
      else n_pass++;
      n_total++;
      if (low != IIS[d] - 1)
         $display("FAIL basic_ready_low[ii=%0d] got %0d exp %0d", IIS[d], low, IIS[d] - 1);
      else n_pass++;
   endtask

   task automatic test_signed(input int d);
      logic [7:0]  ta [3] = '{8'hFF, 8'hFD, 8'h80};
      logic [7:0]  tb [3] = '{8'h80, 8'h05, 8'h80};
      logic [15:0] te [3] = '{16'h0080, 16'hFFF1, 16'h4000};
      logic [15:0] res;
      int lat, low;
      for (int i = 0; i < 3; i++) begin
         run_op(d, ta[i], tb[i], 1'b1, 1'b0, 1'b0, res, lat, low);
         n_total++;
         if (res !== te[i] || lat != IIS[d])
            $display("FAIL signed_%0d[ii=%0d] got %h lat %0d exp %h lat %0d",
                     i, IIS[d], res, lat, te[i], IIS[d]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back(input int d);
      logic [15:0] exp_q [$];
      logic [15:0] e;
      logic [7:0]  a, b;
      logic        s;
      int ii, issued, got, last_t, cyc, drops;
      ii = IIS[d];
      issued = 0; got = 0; last_t = -1; cyc = 0; drops = 0;
      while (got < 50 && cyc < 50 * ii + 50) begin
         if (ready[d] && issued < 50) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
            aa = a; bb = b; sign = s; start[d] = 1'b1;
            exp_q.push_back(16'(ref_mul(a, b, s)));
            issued++;
         end else begin
            start[d] = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (drop[d]) drops++;
         if (out_valid[d]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_total++;
            if (out_v[d] !== e) $display("FAIL b2b_out[ii=%0d] #%0d got %h exp %h", ii, got, out_v[d], e);
            else n_pass++;
            if (last_t >= 0) begin
               n_total++;
               if (cyc - last_t != ii)
                  $display("FAIL b2b_gap[ii=%0d] got %0d exp %0d", ii, cyc - last_t, ii);
               else n_pass++;
            end
            last_t = cyc;
            got++;
         end
      end
      start[d] = 1'b0;
      @(negedge clk);
      n_total++;
      if (got != 50) $display("FAIL b2b_count[ii=%0d] got %0d exp 50", ii, got);
      else n_pass++;
      n_total++;
      if (drops != 0) $display("FAIL b2b_drop[ii=%0d] got %0d exp 0", ii, drops);
      else n_pass++;
   endtask

   task automatic test_drop();
      logic [15:0] res;
      int drops, drop_k, nv, vk;
      drops = 0; drop_k = -1; nv = 0; vk = -1; res = '0;
      aa = 8'h35; bb = 8'hC7; sign = 1'b0; start[0] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (drop[0]) begin
            drops++;
            if (drop_k < 0) drop_k = k;
         end
         if (out_valid[0]) begin
            nv++; vk = k; res = out_v[0];
         end
         if (k == 2) begin
            start[0] = 1'b1; aa = 8'h01; bb = 8'h01;
         end
      end
      n_total++;
      if (drops != 1 || drop_k != 3)
         $display("FAIL drop_pulse got %0d at %0d exp 1 at 3", drops, drop_k);
      else n_pass++;
      n_total++;
      if (nv != 1 || vk != 5) $display("FAIL drop_valid got %0d at %0d exp 1 at 5", nv, vk);
      else n_pass++;
      n_total++;
      if (res !== 16'(ref_mul(8'h35, 8'hC7, 1'b0)))
         $display("FAIL drop_out got %h exp %h", res, 16'(ref_mul(8'h35, 8'hC7, 1'b0)));
      else n_pass++;
   endtask

   task automatic test_acc();
      logic [7:0]  ta [4] = '{8'd3, 8'd5, 8'd2, 8'hFF};
      logic [7:0]  tb [4] = '{8'd4, 8'd6, 8'd2, 8'h01};
      logic        ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [15:0] res;
      int lat, low;
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      acc_model = '0;
      n_total++;
      if (acc_v[0] !== 20'h0) $display("FAIL acc_clr got %h exp 0", acc_v[0]);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         run_op(0, ta[i], tb[i], ts[i], 1'b1, tc[i], res, lat, low);
         n_total++;
         if (acc_v[0] !== acc_model) $display("FAIL acc_%0d got %h exp %h", i, acc_v[0], acc_model);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] res;
      int lat, low, nv;
      nv = 0;
      aa = 8'h12; bb = 8'h34; sign = 1'b0; start[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      rst_n = 1'b0;
      acc_model = '0;
      #1;
      n_total++;
      if (out_v[0] !== 16'h0 || acc_v[0] !== 20'h0 || out_valid[0] !== 1'b0)
         $display("FAIL rst_mid got out=%h acc=%h v=%b exp 0 0 0", out_v[0], acc_v[0], out_valid[0]);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid[0]) nv++;
         if (k == 2) rst_n = 1'b1;
      end
      n_total++;
      if (nv != 0) $display("FAIL rst_mid_valid got %0d exp 0", nv);
      else n_pass++;
      run_op(0, 8'd7, 8'd9, 1'b0, 1'b0, 1'b0, res, lat, low);
      n_total++;
      if (res !== 16'h003F || lat != 4) $display("FAIL rst_mid_op got %h lat %0d exp 003f lat 4", res, lat);
      else n_pass++;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) start[d] = 1'b0;
      test_reset();
      for (int d = 0; d < 3; d++) begin
         test_basic(d);
         test_signed(d);
         test_back_to_back(d);
      end
      test_drop();
      test_acc();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
